// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter and its encoder.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arb4_enc_prio_enc4.sv
// Combinational 4-to-2 priority encoder; bit 0 has the highest priority.
module prio_enc4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] in,
  output logic [IDX_W-1:0] out,
  output logic             found
);

  // Scan from the top so the lowest set bit is the last (winning) assignment
  always_comb begin
    out   = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (in[i]) begin
        out   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb4_enc.sv
// Round-robin arbiter granting one of four requesters a shared encoded resource,
// holding the grant until done, withdrawal, hold timeout or disable.
module rr_arb4_enc
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? CNT_W'(0) : CNT_W'(MAX_HOLD - 1);

  arb_state_e        state;
  logic [IDX_W-1:0]  ptr;
  logic [CNT_W-1:0]  cnt;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   enc_out;
  logic               enc_found;
  logic [IDX_W-1:0]   winner;
  logic               withdrawn;
  logic               hold_expired;

  // Rotate requests so the current priority holder sits at bit 0, then map the
  // encoder result back to an absolute requester index
  always_comb begin
    req_dbl      = {req, req};
    req_rot      = req_dbl[ptr +: N_REQ];
    winner       = enc_out + ptr;
    withdrawn    = ~req[gnt_idx];
    hold_expired = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
  end

  prio_enc4 u_prio_enc4 (
    .in    (req_rot),
    .out   (enc_out),
    .found (enc_found)
  );

  // Arbitration FSM with registered grant, index, hold counter and timeout pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && enc_found) begin
            state     <= ST_GRANT;
            gnt       <= N_REQ'(1) << winner;
            gnt_idx   <= winner;
            gnt_valid <= 1'b1;
            cnt       <= '0;
          end
        end
        ST_GRANT: begin
          if (!en) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            cnt       <= '0;
          end else if (done || withdrawn || hold_expired) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            cnt       <= '0;
            ptr       <= gnt_idx + IDX_W'(1);
            timeout   <= hold_expired && !done;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb4_enc.sv
// Scoreboard bench for rr_arb4_enc: directed vectors push expected grantees,
// a monitor pops them whenever a new grant appears.
module tb_rr_arb4_enc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_q[$];
  logic prev_valid = 1'b0;

  rr_arb4_enc #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] q,
                               input logic d);
    rst_n = r;
    en    = e;
    req   = q;
    done  = d;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg, input logic [1:0] ei,
                             input logic ev, input logic et);
    tests_run++;
    if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev || timeout !== et) begin
      tests_failed++;
      $display("[TB] FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, want gnt=%b idx=%0d valid=%b timeout=%b",
               name, gnt, gnt_idx, gnt_valid, timeout, eg, ei, ev, et);
    end
  endtask

  // Monitor: each newly presented grant is compared against the next expected grantee
  always @(negedge clk) begin
    if (gnt_valid && !prev_valid) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL sb_unexpected: got grant idx=%0d gnt=%b, want no grant", gnt_idx, gnt);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (gnt_idx !== 2'(e) || gnt !== (4'b0001 << e)) begin
          tests_failed++;
          $display("[TB] FAIL sb_grant: got idx=%0d gnt=%b, want idx=%0d gnt=%b",
                   gnt_idx, gnt, e, 4'b0001 << e);
        end
      end
    end
    prev_valid <= gnt_valid;
  end

  initial begin
    int order[5];
    order = '{1, 2, 3, 0, 1};

    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0);
    tick();
    tick();
    checkOutput("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester, then done release (ptr -> 1)
    applyStimulus(1'b1, 1'b1, 4'b0001, 1'b0);
    exp_q.push_back(0);
    tick();
    checkOutput("t1_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    checkOutput("t1_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // All request: rotation 1,2,3,0,1 with a bubble between grants (ptr ends at 2)
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(order[k]);
      tick();
      checkOutput("t2_grant", 4'b0001 << order[k], 2'(order[k]), 1'b1, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      if (k == 4) req = 4'b0000;
      checkOutput("t2_bubble", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // Hold timeout: 16 grant cycles, timeout pulse, regrant after bubble
    req = 4'b0100;
    exp_q.push_back(2);
    tick();
    for (int i = 0; i < 16; i++) begin
      checkOutput("t3_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
      tick();
    end
    checkOutput("t3_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
    exp_q.push_back(2);
    tick();
    checkOutput("t3_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    checkOutput("t3_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Disable mid-grant keeps ptr at 3
    req = 4'b1000;
    exp_q.push_back(3);
    tick();
    checkOutput("t4_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    checkOutput("t4_disable", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1001;
    tick();
    checkOutput("t4_idle_off", 4'b0000, 2'd0, 1'b0, 1'b0);
    en = 1'b1;
    exp_q.push_back(3);
    tick();
    checkOutput("t4_regrant", 4'b1000, 2'd3, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0000;
    checkOutput("t4_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Withdrawal release (ptr -> 2), then grant 2
    req = 4'b0110;
    exp_q.push_back(1);
    tick();
    checkOutput("t5_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0100;
    tick();
    checkOutput("t5_withdraw", 4'b0000, 2'd0, 1'b0, 1'b0);
    exp_q.push_back(2);
    tick();
    checkOutput("t5_next", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Reset mid-grant clears outputs and ptr
    rst_n = 1'b0;
    tick();
    checkOutput("t6_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req   = 4'b1010;
    exp_q.push_back(1);
    tick();
    checkOutput("t6_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    done = 1'b1;
    req  = 4'b0000;
    tick();
    done = 1'b0;

    // done coinciding with hold expiry suppresses timeout (ptr is 2 here)
    req = 4'b0100;
    exp_q.push_back(2);
    tick();
    for (int i = 0; i < 15; i++) tick();
    checkOutput("t7_last_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0000;
    checkOutput("t7_done_wins", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();

    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL sb_drain: got %0d grants still expected, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
